// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width, bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: serial line in, framed byte plus status pulses out.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        input  rx,
        output rx_data, rx_valid, frame_err, rx_busy
    );

    modport slave (
        output rx,
        input  rx_data, rx_valid, frame_err, rx_busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin; 2-cycle latency, no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver; rx_valid/frame_err pulse at the stop-bit mid-sample, about 9.5 bit times
// plus 3 cycles after the start edge. No backpressure: each byte is a single-cycle pulse.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_byte_if.master  bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 8) begin : g_bad_rate
        $error("uart_rx_byte: CLKS_PER_BIT must be at least 8");
    end

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    state_t               state,     state_nxt;
    logic [CNT_W-1:0]     cnt,       cnt_nxt;
    logic [IDX_W-1:0]     idx,       idx_nxt;
    logic [DATA_BITS-1:0] shift,     shift_nxt;
    logic [DATA_BITS-1:0] data_q,    data_nxt;
    logic                 valid_q,   valid_nxt;
    logic                 ferr_q,    ferr_nxt;
    logic                 busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
            busy_q  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Re-check at mid start bit so short glitches are dropped silently.
                if (cnt == CNT_MID) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_END) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == IDX_LAST) state_nxt = STOP;
                    else                 idx_nxt   = idx + IDX_W'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so a following start edge half a bit later is caught.
                if (cnt == CNT_END) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = busy_q;
endmodule
